// File: rtl/clk_mode_ctrl.sv
// APB-programmable CPU clock-mode controller: sequences RUN/SLOW/WAIT_IDLE/GATED/WAKE
// and drives the clock generator's slow-select (gate_en0) and gate (gate_en1) inputs.
module clk_mode_ctrl #(
  parameter logic [7:0]  RST_SETTLE  = 8'd16,
  parameter logic [15:0] RST_TIMEOUT = 16'hFFFF
) (
  input  logic        i_pad_clk,
  input  logic        clkrst_b,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        cpu_wfi,
  input  logic        wake_req,
  output logic        gate_en0,
  output logic        gate_en1,
  output logic        wake_irq
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SLOW      = 3'd1,
    ST_WAIT_IDLE = 3'd2,
    ST_GATED     = 3'd3,
    ST_WAKE      = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  mode_req;
  logic [7:0]  settle_reg;
  logic [15:0] timeout_reg;
  logic        to_flag;

  logic        wake_meta;
  logic        wake_s;

  logic [1:0]  idle_cnt;
  logic [15:0] to_cnt;
  logic [7:0]  settle_cnt;

  logic        apb_wr;
  logic        wr_ctrl;
  logic        wr_settle;
  logic        wr_status;
  logic        wr_timeout;
  logic        ctrl_wr_run;
  logic        ctrl_wr_slow;

  logic        to_set;
  logic        ctrl_clear;
  logic        load_settle;

  logic        unused_bits;

  assign unused_bits = ^{paddr[1:0], pwdata[31:16]};

  assign apb_wr     = psel & penable & pwrite;
  assign wr_ctrl    = apb_wr && (paddr[3:2] == 2'd0);
  assign wr_settle  = apb_wr && (paddr[3:2] == 2'd1);
  assign wr_status  = apb_wr && (paddr[3:2] == 2'd2);
  assign wr_timeout = apb_wr && (paddr[3:2] == 2'd3);

  // Same-cycle CTRL writes are seen directly so they can pre-empt idle/timeout decisions.
  assign ctrl_wr_run  = wr_ctrl && (pwdata[1:0] == 2'b00);
  assign ctrl_wr_slow = wr_ctrl && (pwdata[1:0] == 2'b01);

  always_comb begin
    state_next  = state;
    to_set      = 1'b0;
    ctrl_clear  = 1'b0;
    load_settle = 1'b0;
    case (state)
      ST_RUN: begin
        if (mode_req == 2'b01) begin
          state_next = ST_SLOW;
        end else if (mode_req == 2'b10) begin
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_SLOW: begin
        if (mode_req == 2'b00) begin
          state_next = ST_RUN;
        end else if (mode_req == 2'b10) begin
          state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (ctrl_wr_run) begin
          state_next = ST_RUN;
        end else if (ctrl_wr_slow) begin
          state_next = ST_SLOW;
        end else if (cpu_wfi && (idle_cnt != 2'd0)) begin
          state_next = ST_GATED;
        end else if ((timeout_reg != 16'd0) && (to_cnt == timeout_reg - 16'd1)) begin
          state_next = ST_RUN;
          to_set     = 1'b1;
          ctrl_clear = 1'b1;
        end
      end
      ST_GATED: begin
        if (wake_s || ctrl_wr_run) begin
          state_next  = ST_WAKE;
          load_settle = 1'b1;
        end
      end
      ST_WAKE: begin
        if (settle_cnt <= 8'd1) begin
          state_next = ST_RUN;
          ctrl_clear = 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Gate enables are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge i_pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      state    <= ST_RUN;
      gate_en0 <= 1'b0;
      gate_en1 <= 1'b0;
      wake_irq <= 1'b0;
    end else begin
      state    <= state_next;
      gate_en0 <= (state_next == ST_SLOW);
      gate_en1 <= (state_next == ST_GATED);
      wake_irq <= (state == ST_WAKE) && (state_next == ST_RUN);
    end
  end

  always_ff @(posedge i_pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      wake_meta <= 1'b0;
      wake_s    <= 1'b0;
    end else begin
      wake_meta <= wake_req;
      wake_s    <= wake_meta;
    end
  end

  always_ff @(posedge i_pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      mode_req    <= 2'b00;
      settle_reg  <= RST_SETTLE;
      timeout_reg <= RST_TIMEOUT;
      to_flag     <= 1'b0;
    end else begin
      if (ctrl_clear) begin
        mode_req <= 2'b00;
      end else if (wr_ctrl && (pwdata[1:0] != 2'b11)) begin
        mode_req <= pwdata[1:0];
      end
      if (wr_settle) begin
        settle_reg <= pwdata[7:0];
      end
      if (wr_timeout) begin
        timeout_reg <= pwdata[15:0];
      end
      if (to_set) begin
        to_flag <= 1'b1;
      end else if (wr_status && pwdata[4]) begin
        to_flag <= 1'b0;
      end
    end
  end

  // Idle/timeout counters only run inside WAIT_IDLE and are zero on entry.
  always_ff @(posedge i_pad_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      idle_cnt   <= 2'd0;
      to_cnt     <= 16'd0;
      settle_cnt <= 8'd0;
    end else begin
      if (state != ST_WAIT_IDLE) begin
        idle_cnt <= 2'd0;
        to_cnt   <= 16'd0;
      end else begin
        if (!cpu_wfi) begin
          idle_cnt <= 2'd0;
        end else if (idle_cnt != 2'd3) begin
          idle_cnt <= idle_cnt + 2'd1;
        end
        if (to_cnt != 16'hFFFF) begin
          to_cnt <= to_cnt + 16'd1;
        end
      end
      if (load_settle) begin
        settle_cnt <= settle_reg;
      end else if ((state == ST_WAKE) && (settle_cnt != 8'd0)) begin
        settle_cnt <= settle_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite) begin
      case (paddr[3:2])
        2'd0:    prdata = {30'd0, mode_req};
        2'd1:    prdata = {24'd0, settle_reg};
        2'd2:    prdata = {27'd0, to_flag, 1'b0, state};
        default: prdata = {16'd0, timeout_reg};
      endcase
    end
  end

endmodule

// File: tb/tb_clk_mode_ctrl.sv
// Directed test-plan walk followed by randomized traffic checked against a cycle-level
// behavioural model of the clock-mode controller.
module tb_clk_mode_ctrl;

  logic        i_pad_clk;
  logic        clkrst_b;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        cpu_wfi;
  logic        wake_req;
  logic        gate_en0;
  logic        gate_en1;
  logic        wake_irq;

  int checks   = 0;
  int failures = 0;

  // Model: phase codes follow the visible STATUS encoding (0 run,1 slow,2 wait,3 gated,4 wake).
  int m_phase;
  int m_ctrl;
  int m_settle;
  int m_timeout;
  int m_to;
  int m_sync1;
  int m_sync2;
  int m_wfi_streak;
  int m_waited;
  int m_remaining;
  int m_ge0;
  int m_ge1;
  int m_irq;

  clk_mode_ctrl dut (
    .i_pad_clk (i_pad_clk),
    .clkrst_b  (clkrst_b),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .cpu_wfi   (cpu_wfi),
    .wake_req  (wake_req),
    .gate_en0  (gate_en0),
    .gate_en1  (gate_en1),
    .wake_irq  (wake_irq)
  );

  initial i_pad_clk = 1'b0;
  always #5 i_pad_clk = ~i_pad_clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_ctrl       = 0;
    m_settle     = 16;
    m_timeout    = 65535;
    m_to         = 0;
    m_sync1      = 0;
    m_sync2      = 0;
    m_wfi_streak = 0;
    m_waited     = 0;
    m_remaining  = 0;
    m_ge0        = 0;
    m_ge1        = 0;
    m_irq        = 0;
  endtask

  // Advances the model by one clock using the inputs that are about to be sampled.
  task automatic model_step();
    int  nxt;
    int  n_ctrl;
    int  n_to;
    int  n_rem;
    int  addr_sel;
    int  wr_mode;
    bit  wr;
    bit  wr_back_to_run;
    bit  wr_to_slow;
    wr             = psel && penable && pwrite;
    addr_sel       = int'(paddr[3:2]);
    wr_mode        = int'(pwdata[1:0]);
    wr_back_to_run = wr && addr_sel == 0 && wr_mode == 0;
    wr_to_slow     = wr && addr_sel == 0 && wr_mode == 1;
    nxt    = m_phase;
    n_ctrl = m_ctrl;
    n_to   = m_to;
    n_rem  = m_remaining;
    if (wr && addr_sel == 0 && wr_mode != 3) n_ctrl = wr_mode;
    if (wr && addr_sel == 2 && pwdata[4]) n_to = 0;
    if (m_phase == 0) begin
      if (m_ctrl == 1) nxt = 1;
      else if (m_ctrl == 2) nxt = 2;
    end else if (m_phase == 1) begin
      if (m_ctrl == 0) nxt = 0;
      else if (m_ctrl == 2) nxt = 2;
    end else if (m_phase == 2) begin
      if (wr_back_to_run) nxt = 0;
      else if (wr_to_slow) nxt = 1;
      else if (cpu_wfi && m_wfi_streak >= 1) nxt = 3;
      else if (m_timeout != 0 && m_waited == m_timeout - 1) begin
        nxt    = 0;
        n_to   = 1;
        n_ctrl = 0;
      end
    end else if (m_phase == 3) begin
      if (m_sync2 != 0 || wr_back_to_run) begin
        nxt   = 4;
        n_rem = m_settle;
      end
    end else begin
      if (m_remaining <= 1) begin
        nxt    = 0;
        n_ctrl = 0;
      end else begin
        n_rem = m_remaining - 1;
      end
    end
    if (m_phase == 2) begin
      m_waited     = (m_waited < 65535) ? m_waited + 1 : 65535;
      m_wfi_streak = cpu_wfi ? m_wfi_streak + 1 : 0;
    end else begin
      m_waited     = 0;
      m_wfi_streak = 0;
    end
    if (wr && addr_sel == 1) m_settle = int'(pwdata[7:0]);
    if (wr && addr_sel == 3) m_timeout = int'(pwdata[15:0]);
    m_irq       = (m_phase == 4 && nxt == 0) ? 1 : 0;
    m_ge0       = (nxt == 1) ? 1 : 0;
    m_ge1       = (nxt == 3) ? 1 : 0;
    m_phase     = nxt;
    m_ctrl      = n_ctrl;
    m_to        = n_to;
    m_remaining = n_rem;
    m_sync2     = m_sync1;
    m_sync1     = wake_req ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge i_pad_clk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    tick();
    penable = 1'b1;
    tick();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    pwdata  = 32'd0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    psel    = 1'b1;
    pwrite  = 1'b0;
    penable = 1'b0;
    paddr   = a;
    #1;
    d       = prdata;
    psel    = 1'b0;
    paddr   = 4'd0;
  endtask

  task automatic apply_stimulus();
    logic [3:0]  a;
    logic [31:0] d;
    cpu_wfi = ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 9) == 0) wake_req = ~wake_req;
    if ($urandom_range(0, 5) == 0) begin
      a = 4'($urandom_range(0, 3) * 4);
      case (a)
        4'h0:    d = $urandom;
        4'h4:    d = 32'($urandom_range(0, 5));
        4'h8:    d = $urandom;
        default: d = 32'($urandom_range(0, 12));
      endcase
      apb_write(a, d);
    end else begin
      tick();
    end
  endtask

  task automatic compare_model();
    logic [31:0] rd;
    check_output("rand_gate_en0", {31'd0, gate_en0}, 32'(m_ge0));
    check_output("rand_gate_en1", {31'd0, gate_en1}, 32'(m_ge1));
    check_output("rand_wake_irq", {31'd0, wake_irq}, 32'(m_irq));
    check_output("rand_gate_exclusive", {31'd0, gate_en0 & gate_en1}, 32'd0);
    apb_read(4'h8, rd);
    check_output("rand_status", rd, 32'((m_to << 4) | m_phase));
    apb_read(4'h0, rd);
    check_output("rand_ctrl", rd, 32'(m_ctrl));
  endtask

  initial begin
    logic [31:0] rd;
    int          irq_count;
    int          wake_cycles;
    bit          ge1_seen;

    clkrst_b = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 4'd0;
    pwdata   = 32'd0;
    cpu_wfi  = 1'b0;
    wake_req = 1'b0;
    model_reset();
    #22;
    clkrst_b = 1'b1;

    check_output("reset_gate_en0", {31'd0, gate_en0}, 32'd0);
    check_output("reset_gate_en1", {31'd0, gate_en1}, 32'd0);
    check_output("reset_wake_irq", {31'd0, wake_irq}, 32'd0);
    check_output("idle_bus_prdata", prdata, 32'd0);
    apb_read(4'h0, rd);  check_output("reset_ctrl", rd, 32'd0);
    apb_read(4'h4, rd);  check_output("reset_settle", rd, 32'h10);
    apb_read(4'h8, rd);  check_output("reset_status", rd, 32'd0);
    apb_read(4'hC, rd);  check_output("reset_timeout", rd, 32'hFFFF);

    apb_write(4'h0, 32'd1);
    check_output("slow_write_edge_ge0", {31'd0, gate_en0}, 32'd0);
    tick();
    check_output("slow_ge0", {31'd0, gate_en0}, 32'd1);
    apb_read(4'h8, rd);  check_output("slow_status", rd, 32'd1);
    apb_write(4'h0, 32'd0);
    tick();
    check_output("run_ge0", {31'd0, gate_en0}, 32'd0);
    apb_read(4'h8, rd);  check_output("run_status", rd, 32'd0);

    apb_write(4'h4, 32'd4);
    apb_write(4'h0, 32'd2);
    tick();
    apb_read(4'h8, rd);  check_output("wait_status", rd, 32'd2);
    cpu_wfi = 1'b1;
    tick();
    check_output("wfi_one_cycle_ge1", {31'd0, gate_en1}, 32'd0);
    tick();
    check_output("gated_ge1", {31'd0, gate_en1}, 32'd1);
    apb_read(4'h8, rd);  check_output("gated_status", rd, 32'd3);
    cpu_wfi  = 1'b0;
    wake_req = 1'b1;
    tick();
    check_output("wake_edge1_ge1", {31'd0, gate_en1}, 32'd1);
    tick();
    check_output("wake_edge2_ge1", {31'd0, gate_en1}, 32'd1);
    wake_req = 1'b0;
    tick();
    check_output("wake_edge3_ge1", {31'd0, gate_en1}, 32'd0);
    apb_read(4'h8, rd);  check_output("wake_status", rd, 32'd4);
    irq_count = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      irq_count += int'(wake_irq);
    end
    check_output("settle_no_early_irq", 32'(irq_count), 32'd0);
    apb_read(4'h8, rd);  check_output("settle_still_wake", rd, 32'd4);
    tick();
    check_output("settle_irq", {31'd0, wake_irq}, 32'd1);
    apb_read(4'h8, rd);  check_output("settle_run", rd, 32'd0);
    apb_read(4'h0, rd);  check_output("settle_ctrl_cleared", rd, 32'd0);
    tick();
    check_output("irq_single_cycle", {31'd0, wake_irq}, 32'd0);

    apb_write(4'hC, 32'd8);
    apb_write(4'h0, 32'd2);
    tick();
    ge1_seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      ge1_seen |= gate_en1;
    end
    apb_read(4'h8, rd);  check_output("timeout_still_wait", rd, 32'd2);
    tick();
    ge1_seen |= gate_en1;
    apb_read(4'h8, rd);  check_output("timeout_status", rd, 32'h10);
    apb_read(4'h0, rd);  check_output("timeout_ctrl", rd, 32'd0);
    check_output("timeout_no_gate", {31'd0, ge1_seen}, 32'd0);
    apb_write(4'h8, 32'h10);
    apb_read(4'h8, rd);  check_output("to_flag_w1c", rd, 32'd0);

    apb_write(4'h0, 32'd2);
    tick();
    cpu_wfi = 1'b1;
    tick();
    tick();
    cpu_wfi = 1'b0;
    apb_read(4'h8, rd);  check_output("dual_gated", rd, 32'd3);
    wake_req = 1'b1;
    tick();
    apb_write(4'h0, 32'd0);
    wake_req    = 1'b0;
    irq_count   = 0;
    wake_cycles = 0;
    apb_read(4'h8, rd);
    if (rd == 32'd4) wake_cycles++;
    for (int i = 0; i < 10; i++) begin
      tick();
      irq_count += int'(wake_irq);
      apb_read(4'h8, rd);
      if (rd == 32'd4) wake_cycles++;
    end
    check_output("dual_wake_cycles", 32'(wake_cycles), 32'd4);
    check_output("dual_irq_count", 32'(irq_count), 32'd1);
    apb_read(4'h8, rd);  check_output("dual_end_run", rd, 32'd0);
    apb_write(4'h0, 32'd1);
    apb_write(4'h0, 32'd3);
    apb_read(4'h0, rd);  check_output("ctrl_write11_ignored", rd, 32'd1);
    apb_write(4'h0, 32'd0);
    tick();
    tick();
    check_output("back_to_run_ge0", {31'd0, gate_en0}, 32'd0);

    apb_write(4'h0, 32'd2);
    tick();
    cpu_wfi = 1'b1;
    tick();
    tick();
    cpu_wfi = 1'b0;
    check_output("pre_reset_ge1", {31'd0, gate_en1}, 32'd1);
    #2;
    clkrst_b = 1'b0;
    #1;
    check_output("async_reset_ge1", {31'd0, gate_en1}, 32'd0);
    check_output("async_reset_ge0", {31'd0, gate_en0}, 32'd0);
    model_reset();
    repeat (2) @(posedge i_pad_clk);
    #3;
    clkrst_b = 1'b1;
    apb_read(4'h0, rd);  check_output("post_reset_ctrl", rd, 32'd0);
    apb_read(4'h4, rd);  check_output("post_reset_settle", rd, 32'h10);
    apb_read(4'h8, rd);  check_output("post_reset_status", rd, 32'd0);
    apb_read(4'hC, rd);  check_output("post_reset_timeout", rd, 32'hFFFF);
    tick();
    check_output("post_reset_ge1", {31'd0, gate_en1}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      apply_stimulus();
      compare_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_mode_ctrl.md
Name: clk_mode_ctrl

Overview:
- APB-programmable clock-mode controller that drives the gate_en0 (slow-clock select) and gate_en1 (clock gate) inputs of the system clock generator.
- Sequences CPU clock transitions RUN -> SLOW, and RUN -> wait-for-idle -> GATED -> settle -> RUN.
- Handles the CPU idle handshake, the idle-wait timeout, and asynchronous wake-up.
- Sits on the peripheral APB bus and is clocked by i_pad_clk, so it stays alive while the CPU clock is gated.

Parameters:
- RST_SETTLE, 8'd16, reset value of SETTLE register (wake settle cycles).
- RST_TIMEOUT, 16'hFFFF, reset value of TIMEOUT register (idle-wait limit in cycles).

Ports:
- i_pad_clk  input  1  block clock.
- clkrst_b  input  1  reset, asynchronous, active-low.
- psel  input  1  APB select.
- penable  input  1  APB enable; access phase = psel & penable.
- pwrite  input  1  APB write.
- paddr  input  4  byte address; bits [3:2] decode the register.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data.
- cpu_wfi  input  1  CPU idle indication, synchronous to i_pad_clk.
- wake_req  input  1  asynchronous wake request (interrupt OR).
- gate_en0  output  1  select slow clock for the CPU.
- gate_en1  output  1  gate the CPU clock.
- wake_irq  output  1  one-cycle pulse on return to RUN from WAKE.

Behaviour:
- Reset is clkrst_b, asynchronous, active-low; clock is i_pad_clk.
- Reset values: gate_en0=0, gate_en1=0, wake_irq=0, state=RUN, CTRL=0, SETTLE=RST_SETTLE, TIMEOUT=RST_TIMEOUT, TO_FLAG=0, sync flops=0, counters=0.
- Asserting reset mid-operation forces both gate enables low immediately, without waiting for a clock edge.
- Register map:
  - 0x0 CTRL: [1:0] mode_req, RW. 00=run, 01=slow, 10=gated. A write of 11 is ignored and the register is unchanged.
  - 0x4 SETTLE: [7:0], RW.
  - 0x8 STATUS: RO. [2:0]=state encoding (RUN=0, SLOW=1, WAIT_IDLE=2, GATED=3, WAKE=4). [4]=TO_FLAG, cleared by writing 1 to bit 4.
  - 0xC TIMEOUT: [15:0], RW.
  - Unused bits read 0.
- Writes commit on the rising edge with psel & penable & pwrite; zero wait states.
- prdata is combinational: register value when psel & !pwrite, else 0.
- wake_req passes through a 2-flop synchronizer; wake_s is the second flop output.
- FSM transitions are evaluated each cycle on the current CTRL value:
  - RUN: gate_en0=0, gate_en1=0. mode_req=01 -> SLOW. mode_req=10 -> WAIT_IDLE (clear idle and timeout counters).
  - SLOW: gate_en0=1, gate_en1=0. mode_req=00 -> RUN. mode_req=10 -> WAIT_IDLE.
  - WAIT_IDLE: gate_en0=0, gate_en1=0.
    - Requires cpu_wfi high on 2 consecutive cycles, then -> GATED.
    - Timeout counter increments each cycle. If TIMEOUT!=0 and count==TIMEOUT-1: -> RUN, TO_FLAG=1, CTRL cleared to 00.
    - TIMEOUT=0 disables the timeout.
    - A CTRL write of 00 or 01 goes to RUN or SLOW respectively and takes priority over idle or timeout in the same cycle.
  - GATED: gate_en0=0, gate_en1=1. wake_s=1, or a CTRL write of 00 -> WAKE (settle counter loaded with SETTLE). Both in the same cycle -> single entry to WAKE.
  - WAKE: gate_en0=0, gate_en1=0. Settle counter decrements. On reaching 0 -> RUN, CTRL cleared to 00, and wake_irq=1 for exactly one cycle. SETTLE=0 -> RUN on the next edge.
  - CTRL writes in WAKE update the register only; they are acted on after reaching RUN.
- gate_en0 and gate_en1 are registered state decodes and are never high simultaneously.
- Latency:
  - CTRL write to gate_en change = 1 cycle after the write edge (RUN->SLOW).
  - wake_req rise to leaving GATED = 3 edges.
- TO_FLAG set and a W1C in the same cycle: set wins.
- Idle and timeout counters saturate; they do not wrap.

Test Plan:
- Reset, then read all 4 registers -> CTRL=0, SETTLE=0x10, STATUS=0, TIMEOUT=0xFFFF; gate_en0/1=0.
- Write CTRL=01 -> gate_en0=1 one cycle later, STATUS[2:0]=1. Write CTRL=00 -> gate_en0=0, STATUS=0.
- Write SETTLE=4 and CTRL=10; hold cpu_wfi=1 for 2 cycles -> gate_en1=1. Pulse wake_req -> gate_en1 falls 3 edges later. RUN is reached 4 cycles after that. wake_irq is high for 1 cycle. CTRL reads 0.
- Write TIMEOUT=8 and CTRL=10 with cpu_wfi=0 -> RUN after 8 cycles. STATUS[4]=1, CTRL=0, gate_en1 never asserted. Write 0x10 to STATUS -> STATUS[4]=0.
- In GATED, assert wake_req and write CTRL=00 in the same cycle -> exactly one WAKE pass and one wake_irq pulse. Write CTRL=11 -> CTRL unchanged.
- Assert clkrst_b=0 during GATED -> gate_en1=0 asynchronously. After release: state RUN, all registers at reset values.
